// File: rtl/barrier_core_pkg.sv
// Shared synchronization defines: barrier message formats and the per-thread
// barrier state used by the tile front end.
package barrier_core_pkg;

  localparam int SYNC_BARRIER_ID_W = 10;
  localparam int SYNC_CNT_W        = 10;
  localparam int SYNC_TILE_ID_W    = 4;

  typedef struct packed {
    logic [SYNC_BARRIER_ID_W-1:0] id_barrier;
    logic [SYNC_CNT_W-1:0]        cnt_setup;
    logic [SYNC_TILE_ID_W-1:0]    tile_id_source;
  } sync_account_message_t;

  typedef struct packed {
    logic [SYNC_BARRIER_ID_W-1:0] id_barrier;
  } sync_release_message_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } barrier_thread_state_t;

endpackage

// File: rtl/barrier_core_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer past the winner only when update_en accepts the grant.
module rr_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] request,
  input  logic         update_en,
  output logic [N-1:0] grant
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant  = '0;
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = IDX_W'((int'(ptr) + i) % N);
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        winner     = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (update_en && found) begin
      ptr <= IDX_W'((int'(winner) + 1) % N);
    end
  end

endmodule

// File: rtl/barrier_core.sv
// Per-tile barrier front end: stalls requesting threads, emits one account
// message per request toward the master tile, and un-stalls on release.
module barrier_core
  import barrier_core_pkg::*;
#(
  parameter int TILE_ID      = 0,
  parameter int THREAD_NUMB  = 8,
  parameter int TILE_COUNT   = 16,
  parameter int BARRIER_ID_W = SYNC_BARRIER_ID_W,
  parameter int CNT_W        = SYNC_CNT_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            core_bar_valid,
  input  logic [$clog2(THREAD_NUMB)-1:0]  core_bar_thread,
  input  logic [BARRIER_ID_W-1:0]         core_bar_id,
  input  logic [CNT_W-1:0]                core_bar_cnt,
  output logic [THREAD_NUMB-1:0]          bc_thread_stall,
  output logic                            bc_bar_err,
  output sync_account_message_t           bc_account_mess,
  output logic [$clog2(TILE_COUNT)-1:0]   bc_account_dest,
  output logic                            bc_account_valid,
  input  logic                            ni_account_available,
  input  sync_release_message_t           ni_release_mess,
  input  logic                            ni_release_valid,
  output logic                            bc_release_consumed
);

  localparam int THREAD_W = $clog2(THREAD_NUMB);
  localparam int DEST_W   = $clog2(TILE_COUNT);

  logic                                    reg_free;
  logic [THREAD_NUMB-1:0]                  send_vec;
  logic [THREAD_NUMB-1:0]                  arb_req;
  logic [THREAD_NUMB-1:0]                  grant;
  logic [THREAD_W-1:0]                     winner;
  logic [THREAD_NUMB-1:0][BARRIER_ID_W-1:0] slot_id;
  logic [THREAD_NUMB-1:0][CNT_W-1:0]        slot_cnt;

  // The output register can take a new account when empty or draining this cycle.
  assign reg_free            = !bc_account_valid || ni_account_available;
  assign arb_req             = reg_free ? send_vec : '0;
  assign bc_release_consumed = ni_release_valid;

  rr_arbiter #(.N(THREAD_NUMB)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .request   (arb_req),
    .update_en (reg_free),
    .grant     (grant)
  );

  always_comb begin
    winner = '0;
    for (int i = 0; i < THREAD_NUMB; i++) begin
      if (grant[i]) winner = THREAD_W'(i);
    end
  end

  for (genvar t = 0; t < THREAD_NUMB; t++) begin : g_thread
    barrier_thread_state_t     state_q;
    logic                      stall_q;
    logic [BARRIER_ID_W-1:0]   id_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      req_hit;
    logic                      rel_hit;

    assign req_hit = core_bar_valid && (core_bar_thread == THREAD_W'(t));
    assign rel_hit = ni_release_valid && (ni_release_mess.id_barrier == id_q);

    // A grant in SEND wins over a same-cycle release: the master cannot have
    // released a barrier whose account it has not yet seen from this thread.
    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q <= IDLE;
        stall_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: if (req_hit) begin
            state_q <= SEND;
            stall_q <= 1'b1;
          end
          SEND: if (grant[t]) state_q <= WAIT;
          WAIT: if (rel_hit) begin
            state_q <= IDLE;
            stall_q <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            stall_q <= 1'b0;
          end
        endcase
      end
    end

    // NOTE: slot storage has no reset; it is only read while the FSM is out of
    // IDLE, and every exit from IDLE reloads it.
    always_ff @(posedge clk) begin
      if (state_q == IDLE && req_hit) begin
        id_q  <= core_bar_id;
        cnt_q <= core_bar_cnt;
      end
    end

    assign slot_id[t]         = id_q;
    assign slot_cnt[t]        = cnt_q;
    assign send_vec[t]        = (state_q == SEND);
    assign bc_thread_stall[t] = stall_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bc_bar_err <= 1'b0;
    end else begin
      bc_bar_err <= core_bar_valid && bc_thread_stall[core_bar_thread];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bc_account_valid <= 1'b0;
      bc_account_mess  <= '0;
      bc_account_dest  <= '0;
    end else if (reg_free) begin
      bc_account_valid <= |grant;
      if (|grant) begin
        bc_account_mess <= '{id_barrier:     slot_id[winner],
                             cnt_setup:      slot_cnt[winner],
                             tile_id_source: SYNC_TILE_ID_W'(TILE_ID)};
        bc_account_dest <= slot_id[winner][DEST_W-1:0];
      end
    end
  end

endmodule
